// File: rtl/data_pack.sv
// data_pack: packs 7-bit symbols framed by sop/eop into 32-bit words.
// Each word has four 8-bit lanes {valid_flag, symbol[6:0]}; lane 0 holds the
// first symbol of the word, and unused lanes are all-zero.
// A single registered output stage honours backpressure from the word link.
// Optional feature macro: DATA_PACK_ERR_CNT_EN adds the err_cnt port and a
// saturating protocol-error counter.
//
// state | meaning
// IDLE  | no packet open; only a beat with sop_in is accepted as data
// PACK  | packet open; lane_cnt selects the lane for the next symbol
module data_pack #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 sop_in,
  input  logic                 eop_in,
  input  logic [6:0]           data_in,
  output logic                 ready_out,
  output logic                 valid_out,
  output logic                 sop_out,
  output logic                 eop_out,
  output logic [31:0]          data_out,
  input  logic                 ready_in
`ifdef DATA_PACK_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic {IDLE, PACK} state_t;

  state_t      state, state_nxt;
  logic [1:0]  lane_cnt, lane_nxt;
  logic [23:0] acc, acc_nxt;
  logic        first, first_nxt;
  logic        beat;
  logic        emit, emit_sop, emit_eop;
  logic [31:0] word, merged;
  logic [7:0]  lane_byte;

  // ready_in reaches ready_out combinationally so a held word can drain and
  // be replaced in the same cycle.
  assign ready_out = ~rst & (~valid_out | ready_in);
  assign beat      = valid_in & ready_out;
  assign lane_byte = {1'b1, data_in};
  assign merged    = {8'h00, acc} | ({24'h0, lane_byte} << {lane_cnt, 3'b000});

  // Next-state, lane/accumulator update and word-completion decode.
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane_cnt;
    acc_nxt   = acc;
    first_nxt = first;
    emit      = 1'b0;
    emit_sop  = 1'b0;
    emit_eop  = 1'b0;
    word      = merged;
    if (beat) begin
      if (sop_in) begin
        // A sop always opens a fresh packet; in PACK the partial word is
        // simply overwritten, which discards it.
        if (eop_in) begin
          emit      = 1'b1;
          word      = {24'h0, lane_byte};
          emit_sop  = 1'b1;
          emit_eop  = 1'b1;
          state_nxt = IDLE;
          lane_nxt  = 2'd0;
          acc_nxt   = 24'h0;
          first_nxt = 1'b0;
        end else begin
          state_nxt = PACK;
          lane_nxt  = 2'd1;
          acc_nxt   = {16'h0, lane_byte};
          first_nxt = 1'b1;
        end
      end else if (state == PACK) begin
        if (lane_cnt == 2'd3 || eop_in) begin
          emit      = 1'b1;
          word      = merged;
          emit_sop  = first;
          emit_eop  = eop_in;
          first_nxt = 1'b0;
          lane_nxt  = 2'd0;
          acc_nxt   = 24'h0;
          state_nxt = eop_in ? IDLE : PACK;
        end else begin
          acc_nxt  = merged[23:0];
          lane_nxt = lane_cnt + 2'd1;
        end
      end
    end
  end

  // Packing state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lane_cnt <= 2'd0;
      acc      <= 24'h0;
      first    <= 1'b0;
    end else begin
      state    <= state_nxt;
      lane_cnt <= lane_nxt;
      acc      <= acc_nxt;
      first    <= first_nxt;
    end
  end

  // Output stage: load a completed word, or clear valid once it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      data_out  <= 32'h0;
    end else if (emit) begin
      valid_out <= 1'b1;
      sop_out   <= emit_sop;
      eop_out   <= emit_eop;
      data_out  <= word;
    end else if (ready_in) begin
      valid_out <= 1'b0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
    end
  end

`ifdef DATA_PACK_ERR_CNT_EN
  logic err_beat;

  // An error is a beat without sop while idle, or a sop inside an open packet.
  assign err_beat = beat & (sop_in ? (state == PACK) : (state == IDLE));

  // Saturating protocol-error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_beat && (err_cnt != '1)) begin
      err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_data_pack.sv
// Testbench for data_pack: scenario tasks push expected words into a
// scoreboard queue; a monitor pops and compares each word as it drains.
module tb_data_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, sop_in, eop_in, ready_in;
  logic [6:0]  data_in;
  logic        ready_out, valid_out, sop_out, eop_out;
  logic [31:0] data_out;
`ifdef DATA_PACK_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [33:0] exp_q[$];
  bit rand_on;

  always #5 clk = ~clk;

  data_pack #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sop_in(sop_in), .eop_in(eop_in),
    .data_in(data_in), .ready_out(ready_out), .valid_out(valid_out),
    .sop_out(sop_out), .eop_out(eop_out), .data_out(data_out), .ready_in(ready_in)
`ifdef DATA_PACK_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  task automatic monitor();
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (!rst && valid_out && ready_in) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word got sop=%b eop=%b data=%h, none expected",
                   sop_out, eop_out, data_out);
        end else begin
          e = exp_q.pop_front();
          if ({sop_out, eop_out, data_out} !== e) begin
            failures++;
            $display("FAIL word got sop=%b eop=%b data=%h expected sop=%b eop=%b data=%h",
                     sop_out, eop_out, data_out, e[33], e[32], e[31:0]);
          end
        end
      end
    end
  endtask

  task automatic send(input bit s, input bit e, input logic [6:0] d);
    int n;
    bit ok;
    n = 0;
    valid_in = 1'b1; sop_in = s; eop_in = e; data_in = d;
    forever begin
      @(negedge clk);
      ok = ready_out;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL send_timeout symbol=%h not accepted within 200 cycles", d);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
    while ((exp_q.size() != 0 || valid_out) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (exp_q.size() != 0 || valid_out) begin
      failures++;
      $display("FAIL drain pending_words=%0d valid_out=%b, required 0 and 0", exp_q.size(), valid_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0; data_in = 7'h0; ready_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({valid_out, sop_out, eop_out, data_out} !== 35'h0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b s=%b e=%b d=%h, required all zero", valid_out, sop_out, eop_out, data_out);
    end
    checks++;
    if (ready_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got %b required 0", ready_out);
    end
`ifdef DATA_PACK_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_err_cnt got %0d required 0", err_cnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got %b required 1", ready_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_four();
    exp_q.push_back({2'b11, 32'h84838281});
    send(1, 0, 7'h01); send(0, 0, 7'h02); send(0, 0, 7'h03);
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL four_early_word got valid_out=%b required 0", valid_out);
    end
    send(0, 1, 7'h04);
    checks++;
    if (valid_out !== 1'b1) begin
      failures++;
      $display("FAIL four_latency got valid_out=%b required 1", valid_out);
    end
    drain();
  endtask

  task automatic test_six();
    exp_q.push_back({2'b10, 32'h93929190});
    exp_q.push_back({2'b01, 32'h00009594});
    for (int i = 0; i < 6; i++) send(i == 0, i == 5, 7'(8'h10 + i));
    drain();
  endtask

  task automatic test_single();
    exp_q.push_back({2'b11, 32'h000000FF});
    send(1, 1, 7'h7F);
    checks++;
    if (valid_out !== 1'b1) begin
      failures++;
      $display("FAIL single_latency got valid_out=%b required 1", valid_out);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    time t0;
    exp_q.push_back({2'b11, 32'h00D2D1D0});
    exp_q.push_back({2'b10, 32'hE3E2E1E0});
    exp_q.push_back({2'b01, 32'h000000E4});
    t0 = $time;
    for (int i = 0; i < 3; i++) send(i == 0, i == 2, 7'(8'h50 + i));
    for (int i = 0; i < 5; i++) send(i == 0, i == 4, 7'(8'h60 + i));
    checks++;
    if (($time - t0) != 80) begin
      failures++;
      $display("FAIL throughput got %0t for 8 beats required 80", $time - t0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    exp_q.push_back({2'b10, 32'hA3A2A1A0});
    exp_q.push_back({2'b01, 32'h000000A4});
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) send(i == 0, 0, 7'(8'h20 + i));
    valid_in = 1'b1; sop_in = 1'b0; eop_in = 1'b1; data_in = 7'h24;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ready_out !== 1'b0 || valid_out !== 1'b1 || data_out !== 32'hA3A2A1A0) begin
        failures++;
        $display("FAIL stall got ready_out=%b valid_out=%b data=%h required 0 1 a3a2a1a0",
                 ready_out, valid_out, data_out);
      end
      @(posedge clk);
    end
    #1 ready_in = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b1) begin
      failures++;
      $display("FAIL release_ready got %b required 1", ready_out);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_protocol_errors();
    exp_q.push_back({2'b11, 32'h00000085});
    send(1, 0, 7'h01); send(0, 0, 7'h02); send(1, 1, 7'h05); send(0, 0, 7'h09);
    drain();
`ifdef DATA_PACK_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL err_cnt got %0d required 2", err_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    send(1, 0, 7'h30); send(0, 0, 7'h31);
    valid_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_ready got %b required 0", ready_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({valid_out, sop_out, eop_out, data_out} !== 35'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs got v=%b s=%b e=%b d=%h, required all zero", valid_out, sop_out, eop_out, data_out);
    end
`ifdef DATA_PACK_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_err_cnt got %0d required 0", err_cnt);
    end
`endif
    idle(3);
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_partial got valid_out=%b required 0", valid_out);
    end
    exp_q.push_back({2'b11, 32'hC4C3C2C1});
    for (int i = 0; i < 4; i++) send(i == 0, i == 3, 7'(8'h41 + i));
    drain();
  endtask

  task automatic test_random();
    logic [6:0]  syms[9];
    logic [31:0] w;
    int n, idx;
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          ready_in = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int p = 0; p < 6; p++) begin
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) syms[i] = 7'($urandom_range(0, 127));
      for (int wi = 0; wi * 4 < n; wi++) begin
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
          idx = wi * 4 + k;
          if (idx < n) w[8*k +: 8] = {1'b1, syms[idx]};
        end
        exp_q.push_back({wi == 0, wi * 4 + 4 >= n, w});
      end
      for (int i = 0; i < n; i++) send(i == 0, i == n - 1, syms[i]);
    end
    rand_on = 1'b0;
    @(posedge clk); #2;
    ready_in = 1'b1;
    drain();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_four();
    test_six();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_protocol_errors();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_pack.md
# data_pack

Symbol-to-word packer for the 7-bit symbol stream: accepts one 7-bit symbol per beat, framed by sop/eop, and packs up to four symbols into a 32-bit word with per-lane valid flags. It is the transmit-side counterpart of `data_unpack`, and its output word format is exactly the format `data_unpack` consumes. It sits between the symbol source and the 32-bit word link. Backpressure from the link is honoured through a single registered output stage.

## Interface
Parameters:
- ERR_CNT_W, 8, width of the protocol-error counter; used only when `DATA_PACK_ERR_CNT_EN` is defined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  symbol beat valid.
- sop_in  in  1  first symbol of a packet; qualified by valid_in.
- eop_in  in  1  last symbol of a packet; qualified by valid_in.
- data_in  in  7  symbol.
- ready_out  out  1  block accepts a symbol this cycle.
- valid_out  out  1  data_out/sop_out/eop_out hold a word.
- sop_out  out  1  word is the first of a packet.
- eop_out  out  1  word is the last of a packet.
- data_out  out  32  packed word.
- ready_in  in  1  downstream accepts the word this cycle.
- err_cnt  out  ERR_CNT_W  saturating protocol-error count; present only with `DATA_PACK_ERR_CNT_EN`.

## Operation
- **Word format**
  - Lane k (k = 0..3) occupies data_out[8k+7:8k].
  - Bit 8k+7 is the lane-valid flag; bits [8k+6:8k] carry the symbol.
  - The first symbol of each word goes in lane 0. Unused lanes are all-zero, flag included.
- **Acceptance**
  - A beat transfers when valid_in & ready_out.
  - ready_out = ~rst & (~valid_out | ready_in). This is a combinational path from ready_in.
- **State machine:** IDLE (no packet open) and PACK (packet open); 2-bit lane_cnt; 24-bit partial-word accumulator.
- **IDLE**
  - Beat with sop_in: writes lane 0, sets the first-word flag, and goes to PACK.
  - Beat with sop_in & eop_in: emits a single-lane word with sop_out=eop_out=1 and stays in IDLE.
  - Beat without sop_in: symbol is dropped, counts as an error, state unchanged.
- **PACK**
  - Each beat writes lane lane_cnt.
  - Word is emitted when lane_cnt==3 or eop_in is set; lane_cnt then returns to 0.
  - sop_out is set on the first emitted word of the packet only.
  - eop_in also returns the state to IDLE.
- **Mid-packet sop** (sop_in while in PACK)
  - The partial word is discarded. Words already emitted for that packet stand, without eop.
  - The error counts, and a new packet starts with this symbol in lane 0.
- **Errors:** err_cnt increments by 1 per error beat and saturates at all-ones.

## Timing
- **Reset values:** valid_out=0, sop_out=0, eop_out=0, data_out=0, err_cnt=0, state IDLE, lane_cnt=0, accumulator 0. ready_out is 0 while rst is high.
- **Reset mid-packet:** the partial word and any held output word are discarded.
- **Latency:** a completed word appears on valid_out one cycle after the beat that completes it.
- **Output hold:** outputs are registered and held stable while valid_out & ~ready_in.
- **Throughput:** one symbol per cycle.
- **Full buffer:** with valid_out=1 and ready_in=0, ready_out=0 and no beat is accepted, even a non-completing one.
- **Simultaneous drain and fill:** a word drains and a new word loads in the same cycle with no bubble.

## Configuration
- `DATA_PACK_ERR_CNT_EN` defined: the err_cnt port and counter exist, with the behaviour described above.
- `DATA_PACK_ERR_CNT_EN` undefined: no err_cnt port and no counter. Error beats are still dropped or discarded identically.

## Test plan
- **Four-symbol packet:** symbols 0x01, 0x02, 0x03, 0x04 (sop on the first, eop on the last), ready_in=1 -> one word 32'h84838281 with sop_out=1, eop_out=1, one cycle after the fourth beat.
- **Six-symbol packet:** symbols 0x10..0x15 -> 32'h93929190 (sop_out=1, eop_out=0), then 32'h00009594 (sop_out=0, eop_out=1).
- **Single-symbol packet:** 0x7F with sop_in=eop_in=1 -> 32'h000000FF, sop_out=eop_out=1.
- **Backpressure:**
  - Stimulus: ready_in=0 while a word is valid.
  - Required: data_out is stable and ready_out=0 for every stalled cycle.
  - On ready_in=1, the next word is accepted in the same cycle, and no symbol is lost or duplicated.
- **Protocol errors:**
  - Stimulus: sop + 0x01, 0x02, then sop + 0x05 with eop; then a stray beat 0x09 without sop.
  - Required: the only output is 32'h00000085 with sop_out=eop_out=1.
  - Required: 0x09 is dropped; with the macro defined, err_cnt=2.
- **Reset mid-packet:**
  - Stimulus: rst pulsed for one cycle after two symbols of a packet.
  - Required: every output returns to its reset value and no partial word is emitted.
  - Required: a following four-symbol packet packs from lane 0.
